// File: rtl/shift_unit_mc_if.sv
// Handshake and data bundle for the multicycle ALU shifter.
// The master drives a start request with its operands; the slave
// returns the shifted result with a one-cycle ready pulse.
interface shift_unit_mc_if;
  logic        ctrl_shift;
  logic        ctrl_op;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_operandA;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output ctrl_shift, ctrl_op, ctrl_shiftamt, data_operandA,
    input  data_result, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_shift, ctrl_op, ctrl_shiftamt, data_operandA,
    output data_result, data_resultRDY, busy
  );
endinterface

// File: rtl/shift_unit_mc.sv
// Multicycle 32-bit SLL/SRA shifter for the ALU shift path.
// One log-shifter stage per clock in the order 16, 8, 4, 2, 1 on a
// latched operand. With EARLY_EXIT set the operation finishes as soon as
// no lower shift-amount bits remain, so small or zero amounts complete quickly.
module shift_unit_mc #(
  parameter int EARLY_EXIT = 1
) (
  input logic            clock,
  input logic            reset,
  shift_unit_mc_if.slave sif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         step;
  logic signed [31:0] work;
  logic               op;
  logic [4:0]         shamt;

  logic               start;
  logic               last;
  logic signed [31:0] work_nxt;

  // Shift-amount bit that enables the stage active at this step (16 first).
  function automatic logic stage_bit(input logic [4:0] amt, input logic [2:0] stp);
    case (stp)
      3'd0:    return amt[4];
      3'd1:    return amt[3];
      3'd2:    return amt[2];
      3'd3:    return amt[1];
      default: return amt[0];
    endcase
  endfunction

  // True when every shift-amount bit below the current stage is clear.
  function automatic logic lower_zero(input logic [4:0] amt, input logic [2:0] stp);
    case (stp)
      3'd0:    return amt[3:0] == 4'd0;
      3'd1:    return amt[2:0] == 3'd0;
      3'd2:    return amt[1:0] == 2'd0;
      3'd3:    return amt[0] == 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Fixed stage shift of 16>>step; SRA replicates bit 31 of the work value.
  function automatic logic signed [31:0] stage_shift(input logic signed [31:0] w,
                                                     input logic              sra,
                                                     input logic [2:0]        stp);
    logic [4:0] k;
    k = 5'd16 >> stp;
    return sra ? (w >>> k) : (w << k);
  endfunction

  // Start detection, stage datapath and exit decision for the current step.
  always_comb begin
    start    = 1'b0;
    last     = 1'b0;
    work_nxt = work;
    start    = (state != SHIFT) && sif.ctrl_shift;
    if (stage_bit(shamt, step))
      work_nxt = stage_shift(work, op, step);
    last = (step == 3'd4) || ((EARLY_EXIT != 0) && lower_zero(shamt, step));
  end

  // State register; reset aborts any running operation back to IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_nxt          = state;
    sif.busy           = 1'b0;
    sif.data_resultRDY = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        sif.busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        sif.data_resultRDY = 1'b1;
        state_nxt          = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, one stage per clock, and result capture on exit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step            <= 3'd0;
      work            <= '0;
      op              <= 1'b0;
      shamt           <= 5'd0;
      sif.data_result <= '0;
    end else if (start) begin
      step  <= 3'd0;
      work  <= sif.data_operandA;
      op    <= sif.ctrl_op;
      shamt <= sif.ctrl_shiftamt;
    end else if (state == SHIFT) begin
      work <= work_nxt;
      step <= step + 3'd1;
      if (last) sif.data_result <= work_nxt;
    end
  end

endmodule

// File: tb/tb_shift_unit_mc.sv
// Directed bench for shift_unit_mc: one instance with early exit, one
// running all five stages, driven with identical stimulus.
module tb_shift_unit_mc;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  shift_unit_mc_if sif1 ();
  shift_unit_mc_if sif0 ();

  shift_unit_mc #(.EARLY_EXIT(1)) dut1 (.clock(clock), .reset(reset), .sif(sif1));
  shift_unit_mc #(.EARLY_EXIT(0)) dut0 (.clock(clock), .reset(reset), .sif(sif0));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic [4:0]  amt;
    logic [31:0] a;
    logic [31:0] res;
    int          lat1;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sh, input logic op, input logic [4:0] amt, input logic [31:0] a);
    sif1.ctrl_shift = sh; sif1.ctrl_op = op; sif1.ctrl_shiftamt = amt; sif1.data_operandA = a;
    sif0.ctrl_shift = sh; sif0.ctrl_op = op; sif0.ctrl_shiftamt = amt; sif0.data_operandA = a;
  endtask

  // Start one op on both instances and check latency, result and pulse count.
  task automatic run_op(input string name, input vec_t v);
    int lat1, lat0, n1, n0;
    logic [31:0] r1, r0;
    lat1 = 0; lat0 = 0; n1 = 0; n0 = 0; r1 = '0; r0 = '0;
    @(negedge clock);
    drive(1'b1, v.op, v.amt, v.a);
    @(posedge clock); #1;
    drive(1'b0, ~v.op, ~v.amt, ~v.a);
    chk({name, " busy1"}, 32'(sif1.busy), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
      if (sif1.data_resultRDY) begin n1++; if (lat1 == 0) begin lat1 = c; r1 = sif1.data_result; end end
      if (sif0.data_resultRDY) begin n0++; if (lat0 == 0) begin lat0 = c; r0 = sif0.data_result; end end
    end
    chk({name, " lat ee1"}, 32'(lat1), 32'(v.lat1));
    chk({name, " res ee1"}, r1, v.res);
    chk({name, " pulses ee1"}, 32'(n1), 32'd1);
    chk({name, " lat ee0"}, 32'(lat0), 32'd5);
    chk({name, " res ee0"}, r0, v.res);
    chk({name, " hold ee1"}, sif1.data_result, v.res);
  endtask

  initial begin
    int n1;
    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b1, 5'd2,  32'h80000000, 32'hE0000000, 4};
    vecs[1]  = '{1'b0, 5'd31, 32'h00000001, 32'h80000000, 5};
    vecs[2]  = '{1'b1, 5'd31, 32'h7FFFFFFF, 32'h00000000, 5};
    vecs[3]  = '{1'b1, 5'd0,  32'hF0000000, 32'hF0000000, 1};
    vecs[4]  = '{1'b0, 5'd4,  32'h0000000F, 32'h000000F0, 3};
    vecs[5]  = '{1'b1, 5'd16, 32'h80000000, 32'hFFFF8000, 1};
    vecs[6]  = '{1'b0, 5'd8,  32'h12345678, 32'h34567800, 2};
    vecs[7]  = '{1'b1, 5'd8,  32'h12345678, 32'h00123456, 2};
    vecs[8]  = '{1'b0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1};
    vecs[9]  = '{1'b1, 5'd1,  32'h80000001, 32'hC0000000, 5};
    vecs[10] = '{1'b0, 5'd12, 32'hFFFFFFFF, 32'hFFFFF000, 3};
    vecs[11] = '{1'b1, 5'd30, 32'h40000000, 32'h00000001, 4};
    vecs[12] = '{1'b0, 5'd5,  32'h00000003, 32'h00000060, 5};

    drive(1'b0, 1'b0, 5'd0, 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset result", sif1.data_result, 32'h0);
    chk("reset rdy", 32'(sif1.data_resultRDY), 32'd0);
    chk("reset busy", 32'(sif1.busy), 32'd0);
    chk("reset busy ee0", 32'(sif0.busy), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op($sformatf("v%0d", i), vecs[i]);

    // Start request while busy must be ignored.
    @(negedge clock);
    drive(1'b1, 1'b0, 5'd4, 32'h0000000F);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clock);
    drive(1'b1, 1'b1, 5'd1, 32'hFFFFFFFF);
    @(negedge clock);
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    n1 = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (sif1.data_resultRDY) begin
        n1++;
        chk("busy-ignore result", sif1.data_result, 32'h000000F0);
      end
    end
    chk("busy-ignore pulses", 32'(n1), 32'd1);

    // Back-to-back: ctrl_shift held through the RDY cycle.
    @(negedge clock);
    drive(1'b1, 1'b0, 5'd4, 32'h00000001);
    @(posedge clock); #1;
    drive(1'b1, 1'b1, 5'd16, 32'h80000000);
    repeat (2) @(posedge clock);
    #1;
    chk("b2b rdy1 early", 32'(sif1.data_resultRDY), 32'd0);
    @(posedge clock); #1;
    chk("b2b rdy1", 32'(sif1.data_resultRDY), 32'd1);
    chk("b2b res1", sif1.data_result, 32'h00000010);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    chk("b2b rdy drop", 32'(sif1.data_resultRDY), 32'd0);
    chk("b2b busy2", 32'(sif1.busy), 32'd1);
    @(posedge clock); #1;
    chk("b2b rdy2", 32'(sif1.data_resultRDY), 32'd1);
    chk("b2b res2", sif1.data_result, 32'hFFFF8000);
    repeat (8) @(posedge clock);

    // Asynchronous reset in the middle of an operation.
    @(negedge clock);
    drive(1'b1, 1'b0, 5'd31, 32'h00000001);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("abort result", sif1.data_result, 32'h0);
    chk("abort busy", 32'(sif1.busy), 32'd0);
    chk("abort rdy", 32'(sif1.data_resultRDY), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    n1 = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      if (sif1.data_resultRDY || sif0.data_resultRDY) n1++;
    end
    chk("abort no rdy", 32'(n1), 32'd0);
    run_op("after abort", vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
